fp_prealign_pipe: RTL and testbench



---
 rtl/fp_prealign_pipe_if.sv | 38 +++
 rtl/fp_prealign_pipe.sv | 178 +++++++++++++++++
 tb/tb_fp_prealign_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_prealign_pipe_if.sv
// Handshake and data bundle between the FP adder front end, the pre-align
// pipeline and the mantissa adder stage.
interface fp_prealign_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 3
);
  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned AW = MAN_W + 1 + GRS_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     num_a;
  logic [W-1:0]     num_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic             sign_l;
  logic             sign_s;
  logic             swap;
  logic [EXP_W-1:0] exp_out;
  logic [AW-1:0]    man_l;
  logic [AW-1:0]    man_s;
  logic             is_nan;
  logic             is_inf;

  modport master (
    output in_valid, num_a, num_b, op_sub, out_ready,
    input  in_ready, out_valid, sign_l, sign_s, swap, exp_out,
           man_l, man_s, is_nan, is_inf
  );

  modport slave (
    input  in_valid, num_a, num_b, op_sub, out_ready,
    output in_ready, out_valid, sign_l, sign_s, swap, exp_out,
           man_l, man_s, is_nan, is_inf
  );
endinterface

// File: rtl/fp_prealign_pipe.sv
// Two-stage FP add pre-align: stage 1 classifies and orders the operands by
// magnitude, stage 2 right-aligns the smaller mantissa with a sticky LSB.
module fp_prealign_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  fp_prealign_pipe_if.slave bus
);
  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned AW = MAN_W + 1 + GRS_W;

  // Stage 1 registers
  logic             s1_valid_q;
  logic             s1_sign_l_q, s1_sign_l_d;
  logic             s1_sign_s_q, s1_sign_s_d;
  logic             s1_swap_q,   s1_swap_d;
  logic [EXP_W-1:0] s1_exp_q,    s1_exp_d;
  logic             s1_hid_l_q,  s1_hid_l_d;
  logic [MAN_W-1:0] s1_frac_l_q, s1_frac_l_d;
  logic             s1_hid_s_q,  s1_hid_s_d;
  logic [MAN_W-1:0] s1_frac_s_q, s1_frac_s_d;
  logic [EXP_W-1:0] s1_dist_q,   s1_dist_d;
  logic             s1_nan_q,    s1_nan_d;
  logic             s1_inf_q,    s1_inf_d;

  // Stage 2 registers drive the outputs directly
  logic             s2_valid_q;
  logic             s2_sign_l_q, s2_sign_s_q, s2_swap_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [AW-1:0]    s2_man_l_q,  s2_man_l_d;
  logic [AW-1:0]    s2_man_s_q,  s2_man_s_d;
  logic             s2_nan_q,    s2_inf_q;

  logic s1_adv, s2_adv, s1_load, s2_load;

  // A stage may load when it is empty or its occupant moves on this cycle
  assign s2_adv  = ~s2_valid_q | bus.out_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign s1_load = bus.in_valid & s1_adv;
  assign s2_load = s1_valid_q & s2_adv;

  assign bus.in_ready = s1_adv;

  // Stage 1: classify and order
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, eea, eeb;
  logic [MAN_W-1:0] fa, fb;
  logic             nan_a, nan_b, inf_a, inf_b;

  always_comb begin
    sa    = bus.num_a[W-1];
    sb    = bus.num_b[W-1] ^ bus.op_sub;
    ea    = bus.num_a[W-2 -: EXP_W];
    eb    = bus.num_b[W-2 -: EXP_W];
    fa    = bus.num_a[MAN_W-1:0];
    fb    = bus.num_b[MAN_W-1:0];
    eea   = (ea == '0) ? EXP_W'(1) : ea;
    eeb   = (eb == '0) ? EXP_W'(1) : eb;
    nan_a = (&ea) & (|fa);
    nan_b = (&eb) & (|fb);
    inf_a = (&ea) & ~(|fa);
    inf_b = (&eb) & ~(|fb);

    s1_swap_d = {eb, fb} > {ea, fa};
    if (s1_swap_d) begin
      s1_sign_l_d = sb;
      s1_sign_s_d = sa;
      s1_exp_d    = eb;
      s1_hid_l_d  = |eb;
      s1_frac_l_d = fb;
      s1_hid_s_d  = |ea;
      s1_frac_s_d = fa;
      s1_dist_d   = eeb - eea;
    end else begin
      s1_sign_l_d = sa;
      s1_sign_s_d = sb;
      s1_exp_d    = ea;
      s1_hid_l_d  = |ea;
      s1_frac_l_d = fa;
      s1_hid_s_d  = |eb;
      s1_frac_s_d = fb;
      s1_dist_d   = eea - eeb;
    end

    s1_nan_d = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
    s1_inf_d = (inf_a | inf_b) & ~s1_nan_d;
  end

  // Stage 2: align smaller mantissa, folding shifted-out bits into the LSB
  logic [AW-1:0] ext_s, ones;
  logic          lost;

  always_comb begin
    ones       = '1;
    ext_s      = {s1_hid_s_q, s1_frac_s_q, {GRS_W{1'b0}}};
    s2_man_l_d = {s1_hid_l_q, s1_frac_l_q, {GRS_W{1'b0}}};
    lost       = 1'b0;
    s2_man_s_d = '0;
    if (32'(s1_dist_q) >= AW) begin
      s2_man_s_d = AW'(|ext_s);
    end else begin
      lost          = |(ext_s & ~(ones << s1_dist_q));
      s2_man_s_d    = ext_s >> s1_dist_q;
      s2_man_s_d[0] = s2_man_s_d[0] | lost;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_l_q <= 1'b0;
      s1_sign_s_q <= 1'b0;
      s1_swap_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_hid_l_q  <= 1'b0;
      s1_frac_l_q <= '0;
      s1_hid_s_q  <= 1'b0;
      s1_frac_s_q <= '0;
      s1_dist_q   <= '0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= bus.in_valid;
      if (s1_load) begin
        s1_sign_l_q <= s1_sign_l_d;
        s1_sign_s_q <= s1_sign_s_d;
        s1_swap_q   <= s1_swap_d;
        s1_exp_q    <= s1_exp_d;
        s1_hid_l_q  <= s1_hid_l_d;
        s1_frac_l_q <= s1_frac_l_d;
        s1_hid_s_q  <= s1_hid_s_d;
        s1_frac_s_q <= s1_frac_s_d;
        s1_dist_q   <= s1_dist_d;
        s1_nan_q    <= s1_nan_d;
        s1_inf_q    <= s1_inf_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sign_l_q <= 1'b0;
      s2_sign_s_q <= 1'b0;
      s2_swap_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_man_l_q  <= '0;
      s2_man_s_q  <= '0;
      s2_nan_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_sign_l_q <= s1_sign_l_q;
        s2_sign_s_q <= s1_sign_s_q;
        s2_swap_q   <= s1_swap_q;
        s2_exp_q    <= s1_exp_q;
        s2_man_l_q  <= s2_man_l_d;
        s2_man_s_q  <= s2_man_s_d;
        s2_nan_q    <= s1_nan_q;
        s2_inf_q    <= s1_inf_q;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sign_l    = s2_sign_l_q;
  assign bus.sign_s    = s2_sign_s_q;
  assign bus.swap      = s2_swap_q;
  assign bus.exp_out   = s2_exp_q;
  assign bus.man_l     = s2_man_l_q;
  assign bus.man_s     = s2_man_s_q;
  assign bus.is_nan    = s2_nan_q;
  assign bus.is_inf    = s2_inf_q;
endmodule

// File: tb/tb_fp_prealign_pipe.sv
// Bench for fp_prealign_pipe at binary32 widths: directed vector table,
// backpressure / flush sequences and a randomized scoreboard stream.
module tb_fp_prealign_pipe;
  typedef struct packed {
    logic        sign_l;
    logic        sign_s;
    logic        swap;
    logic [7:0]  exp_out;
    logic [26:0] man_l;
    logic [26:0] man_s;
    logic        is_nan;
    logic        is_inf;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        r;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_out  = 0;
  res_t cur_exp;
  res_t sb_q[$];
  vec_t tbl[13];

  fp_prealign_pipe_if #(.EXP_W(8), .MAN_W(23), .GRS_W(3)) bus ();

  fp_prealign_pipe #(.EXP_W(8), .MAN_W(23), .GRS_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t act();
    res_t r;
    r.sign_l  = bus.sign_l;
    r.sign_s  = bus.sign_s;
    r.swap    = bus.swap;
    r.exp_out = bus.exp_out;
    r.man_l   = bus.man_l;
    r.man_s   = bus.man_s;
    r.is_nan  = bus.is_nan;
    r.is_inf  = bus.is_inf;
    return r;
  endfunction

  // Reference: bit-serial shift collecting the sticky bit as it goes
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t        r;
    logic        sa, sb, sw, na, nb, ia, ib;
    logic [7:0]  ea, eb, el, es;
    logic [22:0] fa, fb;
    logic [26:0] ms;
    logic        st;
    int          d;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31] ^ op; eb = b[30:23]; fb = b[22:0];
    sw = (b[30:0] > a[30:0]);
    el = sw ? eb : ea;
    es = sw ? ea : eb;
    r.swap    = sw;
    r.sign_l  = sw ? sb : sa;
    r.sign_s  = sw ? sa : sb;
    r.exp_out = el;
    r.man_l   = {el != 8'd0, (sw ? fb : fa), 3'b000};
    ms        = {es != 8'd0, (sw ? fa : fb), 3'b000};
    d  = ((el == 8'd0) ? 1 : int'(el)) - ((es == 8'd0) ? 1 : int'(es));
    st = 1'b0;
    for (int i = 0; i < d; i++) begin
      st = st | ms[0];
      ms = ms >> 1;
    end
    ms[0]   = ms[0] | st;
    r.man_s = ms;
    na = (ea == 8'hFF) && (fa != 0);
    nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0);
    ib = (eb == 8'hFF) && (fb == 0);
    r.is_nan = na | nb | (ia & ib & (sa ^ sb));
    r.is_inf = (ia | ib) & ~r.is_nan;
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                              input logic sl, input logic ss, input logic sw, input logic [7:0] e,
                              input logic [26:0] ml, input logic [26:0] ms,
                              input logic nan, input logic inf);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.r = '{sl, ss, sw, e, ml, ms, nan, inf};
    return v;
  endfunction

  function automatic logic [31:0] rnd_num(input logic [7:0] base);
    int unsigned sel;
    logic [7:0]  e;
    logic [22:0] f;
    sel = $urandom_range(0, 9);
    f   = 23'($urandom);
    case (sel)
      0: begin e = 8'h00; f = '0; end
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'hFF; f[0] = 1'b1; end
      3: e = 8'h00;
      4, 5, 6: e = base + 8'($urandom_range(0, 4));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard: push on input transfer, pop/compare on output transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) sb_q.push_back(cur_exp);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("result", act(), sb_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input res_t e);
    int unsigned n;
    logic        acc;
    n = 0;
    bus.num_a = a; bus.num_b = b; bus.op_sub = op; cur_exp = e;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bpa[4], bpb[4];
    res_t        snap;
    int          k, base_out;
    time         t0;
    logic        rand_done;

    tbl[0]  = mk(32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 8'h7F, 27'h4000000, 27'h4000000, 0, 0);
    tbl[1]  = mk(32'h3F800000, 32'h40000000, 0, 0, 0, 1, 8'h80, 27'h4000000, 27'h2000000, 0, 0);
    tbl[2]  = mk(32'h3F800000, 32'h40000000, 1, 1, 0, 1, 8'h80, 27'h4000000, 27'h2000000, 0, 0);
    tbl[3]  = mk(32'h4B800000, 32'h3F800001, 0, 0, 0, 0, 8'h97, 27'h4000000, 27'h0000005, 0, 0);
    tbl[4]  = mk(32'h7F000000, 32'h3F800000, 0, 0, 0, 0, 8'hFE, 27'h4000000, 27'h0000001, 0, 0);
    tbl[5]  = mk(32'h00800000, 32'h00000001, 0, 0, 0, 0, 8'h01, 27'h4000000, 27'h0000008, 0, 0);
    tbl[6]  = mk(32'h00000000, 32'h00000000, 0, 0, 0, 0, 8'h00, 27'h0000000, 27'h0000000, 0, 0);
    tbl[7]  = mk(32'h7F800000, 32'h7F800000, 1, 0, 1, 0, 8'hFF, 27'h4000000, 27'h4000000, 1, 0);
    tbl[8]  = mk(32'h7F800000, 32'h7F800000, 0, 0, 0, 0, 8'hFF, 27'h4000000, 27'h4000000, 0, 1);
    tbl[9]  = mk(32'h7FC00000, 32'h3F800000, 0, 0, 0, 0, 8'hFF, 27'h6000000, 27'h0000001, 1, 0);
    tbl[10] = mk(32'hC0400000, 32'h3F000000, 0, 1, 0, 0, 8'h80, 27'h6000000, 27'h1000000, 0, 0);
    tbl[11] = mk(32'h3F800000, 32'hC1200000, 1, 0, 0, 1, 8'h82, 27'h5000000, 27'h0800000, 0, 0);
    tbl[12] = mk(32'h3F800001, 32'h3F800002, 0, 0, 0, 1, 8'h7F, 27'h4000010, 27'h4000008, 0, 0);

    bus.in_valid = 1'b0; bus.num_a = '0; bus.num_b = '0; bus.op_sub = 1'b0;
    bus.out_ready = 1'b1; cur_exp = '0;
    rst_n = 1'b0;
    #13;
    chk("reset_out_valid", bus.out_valid, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid_post", bus.out_valid, 0);
    chk("reset_data", act(), '0);

    // Two-cycle latency on an empty pipe
    send(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].r);
    chk("latency_cycle1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_cycle2", bus.out_valid, 1);
    drain();

    // Directed table, back-to-back: one accept per cycle
    t0 = $time;
    for (int i = 0; i < 13; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r);
    chk("throughput_cycles", ($time - t0) / 10, 13);
    drain();

    // Backpressure: only two transactions fit, outputs frozen while stalled
    for (int i = 0; i < 4; i++) begin
      bpa[i] = {1'b0, 8'(8'd120 + 8'(i)), 23'($urandom)};
      bpb[i] = {1'($urandom), 8'(8'd118 + 8'(2 * i)), 23'($urandom)};
    end
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.num_a = bpa[k]; bus.num_b = bpb[k]; bus.op_sub = 1'(c);
      cur_exp = model(bpa[k], bpb[k], 1'(c));
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready_low", bus.in_ready, 0);
    snap = act();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_held", bus.out_valid, 1);
      chk("bp_frozen", act(), snap);
    end
    base_out = n_out;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      bus.num_a = bpa[k]; bus.num_b = bpb[k]; bus.op_sub = 1'b0;
      cur_exp = model(bpa[k], bpb[k], 1'b0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_drain_count", n_out - base_out, 4);
    chk("bp_drained_valid", bus.out_valid, 0);

    // Randomized stream with random backpressure
    rand_done = 1'b0;
    fork
      begin
        logic [31:0] a, b;
        logic        op;
        logic [7:0]  base;
        for (int i = 0; i < 300; i++) begin
          base = 8'($urandom_range(100, 150));
          a = rnd_num(base); b = rnd_num(base); op = 1'($urandom);
          send(a, b, op, model(a, b, op));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous flush with both stages occupied
    bus.out_ready = 1'b0;
    send(tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].r);
    send(tbl[3].a, tbl[3].b, tbl[3].op, tbl[3].r);
    chk("flush_full", {bus.out_valid, bus.in_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    sb_q.delete();
    #4 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("flush_no_stale", bus.out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
